// File: rtl/umi_req_arbiter.sv
// N-to-1 UMI request arbiter with a one-entry registered output stage.
// Multi-beat transactions hold the grant until their EOM beat is accepted.
module umi_req_arbiter #(
   parameter int N  = 4,
   parameter int CW = 32,
   parameter int AW = 64,
   parameter int DW = 128
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  mode,
   input  logic [N-1:0]          mask,
   input  logic [N-1:0]          umi_in_valid,
   input  logic [N*CW-1:0]       umi_in_cmd,
   input  logic [N*AW-1:0]       umi_in_dstaddr,
   input  logic [N*AW-1:0]       umi_in_srcaddr,
   input  logic [N*DW-1:0]       umi_in_data,
   output logic [N-1:0]          umi_in_ready,
   output logic                  umi_out_valid,
   output logic [CW-1:0]         umi_out_cmd,
   output logic [AW-1:0]         umi_out_dstaddr,
   output logic [AW-1:0]         umi_out_srcaddr,
   output logic [DW-1:0]         umi_out_data,
   input  logic                  umi_out_ready,
   output logic                  lock_active,
   output logic [$clog2(N)-1:0]  grant_id
);

   localparam int IW = $clog2(N);
   localparam logic IDLE   = 1'b0;
   localparam logic LOCKED = 1'b1;

   logic          state;
   logic [IW-1:0] lock_id;
   logic [IW-1:0] ptr;

   logic [N-1:0]  req;
   logic [IW-1:0] rr_sel, pri_sel, sel, idx;
   logic          rr_hit, eligible, load, accept, eom;

   always_comb begin
      req     = umi_in_valid & ~mask;
      rr_sel  = '0;
      rr_hit  = 1'b0;
      idx     = '0;
      // Search starts just past the last requester that completed a transaction.
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!rr_hit && req[idx]) begin
            rr_hit = 1'b1;
            rr_sel = idx;
         end
      end
      pri_sel = '0;
      for (int i = N-1; i >= 0; i--)
         if (req[i]) pri_sel = IW'(i);

      if (state == LOCKED) begin
         sel      = lock_id;
         eligible = umi_in_valid[lock_id];
      end else if (mode) begin
         sel      = pri_sel;
         eligible = |req;
      end else begin
         sel      = rr_sel;
         eligible = rr_hit;
      end

      load   = ~umi_out_valid | umi_out_ready;
      accept = load & eligible & nreset;
      eom    = umi_in_cmd[int'(sel)*CW + 22];

      umi_in_ready = '0;
      for (int i = 0; i < N; i++)
         umi_in_ready[i] = accept && (sel == IW'(i));
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         umi_out_valid   <= 1'b0;
         umi_out_cmd     <= '0;
         umi_out_dstaddr <= '0;
         umi_out_srcaddr <= '0;
         umi_out_data    <= '0;
      end else if (accept) begin
         umi_out_valid   <= 1'b1;
         umi_out_cmd     <= umi_in_cmd[int'(sel)*CW +: CW];
         umi_out_dstaddr <= umi_in_dstaddr[int'(sel)*AW +: AW];
         umi_out_srcaddr <= umi_in_srcaddr[int'(sel)*AW +: AW];
         umi_out_data    <= umi_in_data[int'(sel)*DW +: DW];
      end else if (umi_out_ready) begin
         umi_out_valid   <= 1'b0;
      end
   end

   // ptr only advances on a completed transaction so a burst never skews fairness.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= IDLE;
         lock_id  <= '0;
         ptr      <= IW'(N-1);
         grant_id <= '0;
      end else if (accept) begin
         grant_id <= sel;
         if (eom) begin
            state <= IDLE;
            ptr   <= sel;
         end else begin
            state   <= LOCKED;
            lock_id <= sel;
         end
      end
   end

   assign lock_active = state;

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Directed bench for umi_req_arbiter: N=4, inputs driven and outputs sampled on negedge.
module tb_umi_req_arbiter;

   logic         clk = 1'b0;
   logic         nreset;
   logic         mode;
   logic [3:0]   mask;
   logic [3:0]   valid;
   logic [127:0] cmd;
   logic [255:0] dst;
   logic [255:0] src;
   logic [511:0] data;
   logic [3:0]   ready;
   logic         out_valid;
   logic [31:0]  out_cmd;
   logic [63:0]  out_dst;
   logic [63:0]  out_src;
   logic [127:0] out_data;
   logic         out_ready;
   logic         lock_active;
   logic [1:0]   grant_id;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   umi_req_arbiter #(.N(4), .CW(32), .AW(64), .DW(128)) dut (
      .clk(clk), .nreset(nreset), .mode(mode), .mask(mask),
      .umi_in_valid(valid), .umi_in_cmd(cmd), .umi_in_dstaddr(dst),
      .umi_in_srcaddr(src), .umi_in_data(data), .umi_in_ready(ready),
      .umi_out_valid(out_valid), .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst),
      .umi_out_srcaddr(out_src), .umi_out_data(out_data), .umi_out_ready(out_ready),
      .lock_active(lock_active), .grant_id(grant_id)
   );

   task automatic drive(input int i, input logic v, input logic e, input logic [127:0] d);
      valid[i]          = v;
      cmd[i*32 +: 32]   = e ? 32'h0040_0000 : 32'h0;
      src[i*64 +: 64]   = 64'(i);
      dst[i*64 +: 64]   = 64'h1000 + 64'(i);
      data[i*128 +: 128] = d;
   endtask

   task automatic test_reset;
      nreset = 1'b0; mode = 1'b0; mask = '0; out_ready = 1'b1;
      valid = '0; cmd = '0; dst = '0; src = '0; data = '0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ready); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
      checks++; if (lock_active !== 1'b0) begin errors++; $display("FAIL reset_lock got %b exp 0", lock_active); end
      nreset = 1'b1;
      @(negedge clk);
      checks++; if ({out_valid, ready} !== 5'b0) begin errors++; $display("FAIL idle got %b exp 00000", {out_valid, ready}); end
   endtask

   task automatic test_round_robin;
      for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 128'h100 + 128'(i));
      #1;
      checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b exp 0001", ready); end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, out_src, grant_id} !== {1'b1, 64'(k % 4), 2'(k % 4)}) begin
            errors++; $display("FAIL rr_order[%0d] got v=%b src=%0d gid=%0d exp v=1 src=%0d", k, out_valid, out_src, grant_id, k % 4);
         end
      end
      valid = '0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_multi_beat;
      drive(0, 1'b1, 1'b1, 128'h200);
      drive(1, 1'b1, 1'b1, 128'h201);
      drive(2, 1'b1, 1'b0, 128'h2A0);
      #1;
      checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL mb_ready0 got %b exp 0100", ready); end
      @(negedge clk);
      checks++; if ({out_src, out_data, lock_active} !== {64'd2, 128'h2A0, 1'b1}) begin
         errors++; $display("FAIL mb_beat0 got src=%0d data=%h lock=%b exp 2/2a0/1", out_src, out_data, lock_active); end
      drive(2, 1'b0, 1'b0, 128'h0);
      #1;
      checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL mb_stall_ready got %b exp 0000", ready); end
      @(negedge clk);
      checks++; if ({out_valid, lock_active} !== 2'b01) begin errors++; $display("FAIL mb_stall got v=%b lock=%b exp 0/1", out_valid, lock_active); end
      drive(2, 1'b1, 1'b0, 128'h2A1);
      @(negedge clk);
      checks++; if ({out_valid, out_src, out_data} !== {1'b1, 64'd2, 128'h2A1}) begin
         errors++; $display("FAIL mb_beat1 got src=%0d data=%h exp 2/2a1", out_src, out_data); end
      drive(2, 1'b1, 1'b1, 128'h2A2);
      @(negedge clk);
      checks++; if ({out_src, out_data, lock_active} !== {64'd2, 128'h2A2, 1'b0}) begin
         errors++; $display("FAIL mb_beat2 got src=%0d data=%h lock=%b exp 2/2a2/0", out_src, out_data, lock_active); end
      drive(2, 1'b0, 1'b0, 128'h0);
      @(negedge clk);
      checks++; if (out_src !== 64'd0) begin errors++; $display("FAIL mb_after0 got %0d exp 0", out_src); end
      @(negedge clk);
      checks++; if (out_src !== 64'd1) begin errors++; $display("FAIL mb_after1 got %0d exp 1", out_src); end
      valid = '0;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      drive(0, 1'b1, 1'b1, 128'hA5);
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 128'h0);
      drive(1, 1'b1, 1'b1, 128'hB6);
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if ({out_valid, out_data, ready} !== {1'b1, 128'hA5, 4'b0000}) begin
            errors++; $display("FAIL bp_hold[%0d] got v=%b data=%h ready=%b exp 1/a5/0000", c, out_valid, out_data, ready);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", ready); end
      @(negedge clk);
      checks++; if ({out_valid, out_data} !== {1'b1, 128'hB6}) begin errors++; $display("FAIL bp_next got v=%b data=%h exp 1/b6", out_valid, out_data); end
      drive(1, 1'b0, 1'b1, 128'h0);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_fixed_mask;
      mode = 1'b1; mask = 4'b0001;
      for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 128'h300 + 128'(i));
      #1;
      checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL fp_ready got %b exp 0010", ready); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (out_src !== 64'd1) begin errors++; $display("FAIL fp_grant[%0d] got %0d exp 1", k, out_src); end
      end
      drive(1, 1'b1, 1'b0, 128'h310);
      @(negedge clk);
      checks++; if ({out_src, lock_active} !== {64'd1, 1'b1}) begin errors++; $display("FAIL fp_lock got src=%0d lock=%b exp 1/1", out_src, lock_active); end
      mask = 4'b0000;
      #1;
      checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL fp_midlock_ready got %b exp 0010", ready); end
      drive(1, 1'b1, 1'b1, 128'h311);
      @(negedge clk);
      checks++; if ({out_src, out_data, lock_active} !== {64'd1, 128'h311, 1'b0}) begin
         errors++; $display("FAIL fp_release got src=%0d data=%h lock=%b exp 1/311/0", out_src, out_data, lock_active); end
      #1;
      checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL fp_unmask_ready got %b exp 0001", ready); end
      @(negedge clk);
      checks++; if ({out_src, grant_id} !== {64'd0, 2'd0}) begin errors++; $display("FAIL fp_unmask got src=%0d gid=%0d exp 0/0", out_src, grant_id); end
      valid = '0; mode = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_lock;
      drive(3, 1'b1, 1'b0, 128'h3A0);
      #1;
      checks++; if (ready !== 4'b1000) begin errors++; $display("FAIL rml_ready got %b exp 1000", ready); end
      @(negedge clk);
      checks++; if ({out_src, lock_active, grant_id} !== {64'd3, 1'b1, 2'd3}) begin
         errors++; $display("FAIL rml_lock got src=%0d lock=%b gid=%0d exp 3/1/3", out_src, lock_active, grant_id); end
      nreset = 1'b0;
      #1;
      checks++; if ({lock_active, out_valid, ready} !== 6'b0) begin
         errors++; $display("FAIL rml_async got lock=%b v=%b ready=%b exp 0/0/0000", lock_active, out_valid, ready); end
      @(negedge clk);
      nreset = 1'b1;
      for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 128'h400 + 128'(i));
      #1;
      checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL rml_after_ready got %b exp 0001", ready); end
      @(negedge clk);
      checks++; if ({out_valid, out_src, out_data} !== {1'b1, 64'd0, 128'h400}) begin
         errors++; $display("FAIL rml_first got v=%b src=%0d data=%h exp 1/0/400", out_valid, out_src, out_data); end
      valid = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_multi_beat();
      test_backpressure();
      test_fixed_mask();
      test_reset_mid_lock();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
